eth_cmd_decoder: RTL and testbench

- Consumes the receive AXI-Stream byte stream from the Ethernet MAC interface and decodes raw-Ethernet command frames into configuration registers.
- Replaces the hand-driven VIO settings: MAC addresses, thresholds, channel enable, TDS mode, trigger width and debug enable.
- Sits directly downstream of the MAC rx_axis_fifo port, which was previously tied to tready=1 and left unused.
- Clocked in the MAC clock domain (gtx_clk_bufg_out). Outputs are quasi-static; their CDC to clk160 is handled by the integrator.

---
 rtl/eth_cmd_pkg.sv | 45 ++++
 rtl/eth_cmd_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_eth_cmd_decoder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/eth_cmd_pkg.sv
// Shared constants and types for the Ethernet command-frame decoder.
package eth_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;

  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_ENABLE  = 8'h01;
  localparam logic [7:0] ADDR_CNT_TH  = 8'h02;
  localparam logic [7:0] ADDR_IDLE_TH = 8'h03;
  localparam logic [7:0] ADDR_TRIG_W  = 8'h04;
  localparam logic [7:0] ADDR_DMAC_HI = 8'h05;
  localparam logic [7:0] ADDR_DMAC_LO = 8'h06;
  localparam logic [7:0] ADDR_SMAC_HI = 8'h07;
  localparam logic [7:0] ADDR_SMAC_LO = 8'h08;

  localparam logic [5:0] IDX_DST_LAST   = 6'd5;
  localparam logic [5:0] IDX_ETYPE_HI   = 6'd12;
  localparam logic [5:0] IDX_ETYPE_LO   = 6'd13;
  localparam logic [5:0] IDX_OPCODE     = 6'd14;
  localparam logic [5:0] IDX_ADDR       = 6'd15;
  localparam logic [5:0] IDX_DATA_FIRST = 6'd16;
  localparam logic [5:0] IDX_DATA_LAST  = 6'd19;
  localparam logic [5:0] IDX_MAX        = 6'd63;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_CMD  = 2'd1,
    ST_TAIL = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  // Byte of a MAC address in wire order (index 0 is the most significant byte).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [5:0] idx);
    case (idx)
      6'd0:    return mac[47:40];
      6'd1:    return mac[39:32];
      6'd2:    return mac[31:24];
      6'd3:    return mac[23:16];
      6'd4:    return mac[15:8];
      6'd5:    return mac[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/eth_cmd_decoder.sv
// Decodes raw-Ethernet write-command frames from the MAC rx stream into
// quasi-static configuration registers.
//
// state | meaning
// HDR   | bytes 0-13: destination MAC and EtherType checked byte by byte
// CMD   | bytes 14-19: opcode, address and 32-bit data captured
// TAIL  | bytes 20+: padding, commit on tlast
// DROP  | frame rejected, wait for tlast
module eth_cmd_decoder
  import eth_cmd_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE      = 16'h88B5,
  parameter logic [11:0] DEF_COUNTER_TH = 12'd100,
  parameter logic [15:0] DEF_IDLE_TH    = 16'd1000,
  parameter logic [9:0]  DEF_TRIG_WIDTH = 10'd40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_axis_fifo_tdata,
  input  logic        rx_axis_fifo_tvalid,
  output logic        rx_axis_fifo_tready,
  input  logic        rx_axis_fifo_tlast,
  output logic [47:0] S_MAC_add,
  output logic [47:0] D_MAC_add,
  output logic [11:0] counter_th,
  output logic [15:0] idle_counter_number_th,
  output logic [3:0]  enable,
  output logic        tds_mode,
  output logic        debug_enable,
  output logic        enable_trigger,
  output logic [9:0]  trigger_width,
  output logic        soft_reset,
  output logic [7:0]  frames_accepted,
  output logic [7:0]  frames_dropped
);

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic        ucast_q, ucast_d;
  logic        bcast_q, bcast_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;

  logic        tready_q;
  logic [47:0] smac_q, dmac_q;
  logic [11:0] cnt_th_q;
  logic [15:0] idle_th_q;
  logic [3:0]  enable_q;
  logic        tds_mode_q, debug_q, en_trig_q, soft_reset_q;
  logic [9:0]  trig_w_q;
  logic [7:0]  acc_q, drop_q;

  logic        beat, u_hit, b_hit, commit, drop;
  logic [31:0] wr_data;

  assign beat = rx_axis_fifo_tvalid & tready_q;

  // Each dst byte must keep matching the board MAC or the broadcast address.
  assign u_hit = (rx_axis_fifo_tdata == mac_byte(smac_q, idx_q)) && ((idx_q == 6'd0) || ucast_q);
  assign b_hit = (rx_axis_fifo_tdata == 8'hFF) && ((idx_q == 6'd0) || bcast_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_HDR;
      idx_q   <= 6'd0;
      ucast_q <= 1'b0;
      bcast_q <= 1'b0;
      addr_q  <= 8'h00;
      data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ucast_q <= ucast_d;
      bcast_q <= bcast_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ucast_d = ucast_q;
    bcast_d = bcast_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_data = data_q;
    commit  = 1'b0;
    drop    = 1'b0;
    if (beat) begin
      if (rx_axis_fifo_tlast)     idx_d = 6'd0;
      else if (idx_q != IDX_MAX)  idx_d = idx_q + 6'd1;
      case (state_q)
        ST_HDR: begin
          if (idx_q <= IDX_DST_LAST) begin
            ucast_d = u_hit;
            bcast_d = b_hit;
          end
          if (rx_axis_fifo_tlast) begin
            drop = 1'b1;
          end else if ((idx_q <= IDX_DST_LAST) && !(u_hit || b_hit)) begin
            state_d = ST_DROP;
          end else if ((idx_q == IDX_ETYPE_HI) && (rx_axis_fifo_tdata != ETHERTYPE[15:8])) begin
            state_d = ST_DROP;
          end else if (idx_q == IDX_ETYPE_LO) begin
            state_d = (rx_axis_fifo_tdata == ETHERTYPE[7:0]) ? ST_CMD : ST_DROP;
          end
        end
        ST_CMD: begin
          if (idx_q == IDX_ADDR) addr_d = rx_axis_fifo_tdata;
          if (idx_q >= IDX_DATA_FIRST) data_d = {data_q[23:0], rx_axis_fifo_tdata};
          if (rx_axis_fifo_tlast) begin
            state_d = ST_HDR;
            if (idx_q == IDX_DATA_LAST) begin
              commit  = 1'b1;
              wr_data = {data_q[23:0], rx_axis_fifo_tdata};
            end else begin
              drop = 1'b1;
            end
          end else if ((idx_q == IDX_OPCODE) && (rx_axis_fifo_tdata != OP_WRITE)) begin
            state_d = ST_DROP;
          end else if ((idx_q == IDX_ADDR) && (rx_axis_fifo_tdata > ADDR_SMAC_LO)) begin
            state_d = ST_DROP;
          end else if (idx_q == IDX_DATA_LAST) begin
            state_d = ST_TAIL;
          end
        end
        ST_TAIL: begin
          if (rx_axis_fifo_tlast) begin
            commit  = 1'b1;
            state_d = ST_HDR;
          end
        end
        ST_DROP: begin
          if (rx_axis_fifo_tlast) begin
            drop    = 1'b1;
            state_d = ST_HDR;
          end
        end
        default: state_d = ST_HDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tready_q     <= 1'b0;
      smac_q       <= 48'h00_0A_35_00_00_01;
      dmac_q       <= 48'hFF_FF_FF_FF_FF_FF;
      cnt_th_q     <= DEF_COUNTER_TH;
      idle_th_q    <= DEF_IDLE_TH;
      trig_w_q     <= DEF_TRIG_WIDTH;
      enable_q     <= 4'h0;
      tds_mode_q   <= 1'b0;
      debug_q      <= 1'b0;
      en_trig_q    <= 1'b0;
      soft_reset_q <= 1'b0;
      acc_q        <= 8'h00;
      drop_q       <= 8'h00;
    end else begin
      tready_q     <= 1'b1;
      soft_reset_q <= 1'b0;
      if (commit) begin
        case (addr_q)
          ADDR_CTRL: begin
            soft_reset_q <= wr_data[0];
            tds_mode_q   <= wr_data[1];
            debug_q      <= wr_data[2];
            en_trig_q    <= wr_data[3];
          end
          ADDR_ENABLE:  enable_q         <= wr_data[3:0];
          ADDR_CNT_TH:  cnt_th_q         <= wr_data[11:0];
          ADDR_IDLE_TH: idle_th_q        <= wr_data[15:0];
          ADDR_TRIG_W:  trig_w_q         <= wr_data[9:0];
          ADDR_DMAC_HI: dmac_q[47:16]    <= wr_data;
          ADDR_DMAC_LO: dmac_q[15:0]     <= wr_data[15:0];
          ADDR_SMAC_HI: smac_q[47:16]    <= wr_data;
          ADDR_SMAC_LO: smac_q[15:0]     <= wr_data[15:0];
          default: ;
        endcase
      end
      if (commit && (acc_q != 8'hFF))  acc_q  <= acc_q + 8'd1;
      if (drop && (drop_q != 8'hFF))   drop_q <= drop_q + 8'd1;
    end
  end

  assign rx_axis_fifo_tready    = tready_q;
  assign S_MAC_add              = smac_q;
  assign D_MAC_add              = dmac_q;
  assign counter_th             = cnt_th_q;
  assign idle_counter_number_th = idle_th_q;
  assign enable                 = enable_q;
  assign tds_mode               = tds_mode_q;
  assign debug_enable           = debug_q;
  assign enable_trigger         = en_trig_q;
  assign trigger_width          = trig_w_q;
  assign soft_reset             = soft_reset_q;
  assign frames_accepted        = acc_q;
  assign frames_dropped         = drop_q;

endmodule

// File: tb/tb_eth_cmd_decoder.sv
// Directed bench for eth_cmd_decoder: hand-built command frames with
// hand-computed register values.
module tb_eth_cmd_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  tdata = 8'h00;
  logic        tvalid = 1'b0;
  logic        tready;
  logic        tlast = 1'b0;
  logic [47:0] s_mac, d_mac;
  logic [11:0] counter_th;
  logic [15:0] idle_th;
  logic [3:0]  enable;
  logic        tds_mode, debug_enable, enable_trigger, soft_reset;
  logic [9:0]  trigger_width;
  logic [7:0]  frames_accepted, frames_dropped;

  int checks = 0;
  int errors = 0;

  localparam logic [47:0] BOARD1 = 48'h00_0A_35_00_00_01;
  localparam logic [47:0] BOARD2 = 48'h00_0A_35_00_00_02;
  localparam logic [47:0] BCAST  = 48'hFF_FF_FF_FF_FF_FF;

  always #4 clk = ~clk;

  eth_cmd_decoder dut (
    .clk                    (clk),
    .reset                  (reset),
    .rx_axis_fifo_tdata     (tdata),
    .rx_axis_fifo_tvalid    (tvalid),
    .rx_axis_fifo_tready    (tready),
    .rx_axis_fifo_tlast     (tlast),
    .S_MAC_add              (s_mac),
    .D_MAC_add              (d_mac),
    .counter_th             (counter_th),
    .idle_counter_number_th (idle_th),
    .enable                 (enable),
    .tds_mode               (tds_mode),
    .debug_enable           (debug_enable),
    .enable_trigger         (enable_trigger),
    .trigger_width          (trigger_width),
    .soft_reset             (soft_reset),
    .frames_accepted        (frames_accepted),
    .frames_dropped         (frames_dropped)
  );

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [47:0] dst, input logic [15:0] et,
                                         input logic [7:0] op, input logic [7:0] addr,
                                         input logic [31:0] data, input int i);
    if (i < 6)        return dst[8*(5-i) +: 8];
    else if (i < 12)  return 8'hAA;
    else if (i == 12) return et[15:8];
    else if (i == 13) return et[7:0];
    else if (i == 14) return op;
    else if (i == 15) return addr;
    else if (i < 20)  return data[8*(19-i) +: 8];
    else              return 8'h00;
  endfunction

  // Sends bytes [first, stop) of a frame of length len; gap inserts one idle cycle before that byte.
  task automatic send_range(input logic [47:0] dst, input logic [15:0] et, input logic [7:0] op,
                            input logic [7:0] addr, input logic [31:0] data,
                            input int first, input int stop, input int len, input int gap);
    for (int i = first; i < stop; i++) begin
      @(negedge clk);
      if (i == gap) begin
        tvalid = 1'b0;
        tlast  = 1'b0;
        @(negedge clk);
      end
      tvalid = 1'b1;
      tdata  = byte_at(dst, et, op, addr, data, i);
      tlast  = (i == len - 1);
    end
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input logic [7:0] op,
                            input logic [7:0] addr, input logic [31:0] data, input int len);
    send_range(dst, et, op, addr, data, 0, len, len, -1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("tready_in_reset", tready, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("tready_after_reset", tready, 1'b1);
    chk("rst_smac", s_mac, BOARD1);
    chk("rst_dmac", d_mac, BCAST);
    chk("rst_counter_th", counter_th, 12'd100);
    chk("rst_idle_th", idle_th, 16'd1000);
    chk("rst_trig_w", trigger_width, 10'd40);
    chk("rst_enable", enable, 4'h0);
    chk("rst_ctrl", {tds_mode, debug_enable, enable_trigger, soft_reset}, 4'b0000);
    chk("rst_acc", frames_accepted, 8'd0);
    chk("rst_drop", frames_dropped, 8'd0);

    // 60-byte write to counter_th, with a tvalid bubble inside the header
    send_range(BOARD1, 16'h88B5, 8'h01, 8'h02, 32'h0000_0123, 0, 60, 60, 9);
    chk("cnt_th_write", counter_th, 12'h123);
    chk("acc_1", frames_accepted, 8'd1);
    chk("drop_0", frames_dropped, 8'd0);

    send_frame(BOARD1, 16'h0800, 8'h01, 8'h02, 32'h0000_0456, 60);
    chk("bad_etype_cnt_th", counter_th, 12'h123);
    chk("drop_1", frames_dropped, 8'd1);
    chk("acc_still_1", frames_accepted, 8'd1);

    send_frame(BCAST, 16'h88B5, 8'h01, 8'h00, 32'h0000_0003, 60);
    chk("soft_reset_pulse", soft_reset, 1'b1);
    chk("tds_mode_set", tds_mode, 1'b1);
    chk("debug_clear", debug_enable, 1'b0);
    @(negedge clk);
    chk("soft_reset_cleared", soft_reset, 1'b0);
    chk("tds_mode_held", tds_mode, 1'b1);
    chk("acc_2", frames_accepted, 8'd2);

    send_frame(BOARD1, 16'h88B5, 8'h01, 8'h00, 32'h0000_000C, 60);
    chk("ctrl_c", {tds_mode, debug_enable, enable_trigger, soft_reset}, 4'b0110);
    chk("acc_3", frames_accepted, 8'd3);

    // tlast at index 17: short frame dropped, parser recovers
    send_frame(BOARD1, 16'h88B5, 8'h01, 8'h02, 32'h0000_0456, 18);
    chk("short_cnt_th", counter_th, 12'h123);
    chk("drop_2", frames_dropped, 8'd2);
    send_frame(BOARD1, 16'h88B5, 8'h01, 8'h01, 32'h0000_00F5, 60);
    chk("enable_write", enable, 4'h5);
    chk("acc_4", frames_accepted, 8'd4);

    // exactly 20 bytes: commit on tlast at index 19; upper data bits ignored
    send_frame(BOARD1, 16'h88B5, 8'h01, 8'h04, 32'hFFFF_FFFF, 20);
    chk("trig_w_20byte", trigger_width, 10'h3FF);
    chk("acc_5", frames_accepted, 8'd5);

    send_frame(BOARD1, 16'h88B5, 8'h01, 8'h09, 32'h0000_0001, 60);
    chk("bad_addr_drop", frames_dropped, 8'd3);
    chk("bad_addr_acc", frames_accepted, 8'd5);

    send_frame(BOARD1, 16'h88B5, 8'h02, 8'h01, 32'h0000_000A, 60);
    chk("bad_op_enable", enable, 4'h5);
    chk("bad_op_drop", frames_dropped, 8'd4);

    send_frame(BOARD1, 16'h88B5, 8'h01, 8'h08, 32'h0000_0002, 60);
    chk("smac_write", s_mac, BOARD2);
    chk("acc_6", frames_accepted, 8'd6);
    send_frame(BOARD1, 16'h88B5, 8'h01, 8'h03, 32'h0000_BEEF, 60);
    chk("old_mac_idle", idle_th, 16'd1000);
    chk("old_mac_drop", frames_dropped, 8'd5);
    send_frame(BOARD2, 16'h88B5, 8'h01, 8'h03, 32'h0001_BEEF, 60);
    chk("new_mac_idle", idle_th, 16'hBEEF);
    chk("acc_7", frames_accepted, 8'd7);

    send_frame(BOARD2, 16'h88B5, 8'h01, 8'h05, 32'h1122_3344, 60);
    send_frame(BOARD2, 16'h88B5, 8'h01, 8'h06, 32'hAAAA_5566, 60);
    chk("dmac_write", d_mac, 48'h1122_3344_5566);
    chk("acc_9", frames_accepted, 8'd9);

    // one-byte frames, each dropped in the header, drive the counter into saturation
    for (int n = 0; n < 260; n++) send_frame(BOARD2, 16'h88B5, 8'h01, 8'h00, 32'h0, 1);
    chk("drop_saturate", frames_dropped, 8'hFF);
    chk("acc_unchanged", frames_accepted, 8'd9);

    // reset asserted while byte 16 of a write frame is on the bus
    send_range(BOARD2, 16'h88B5, 8'h01, 8'h02, 32'h0000_0456, 0, 16, 60, -1);
    reset  = 1'b1;
    tvalid = 1'b1;
    tdata  = byte_at(BOARD2, 16'h88B5, 8'h01, 8'h02, 32'h0000_0456, 16);
    repeat (2) @(negedge clk);
    chk("midrst_tready", tready, 1'b0);
    chk("midrst_smac", s_mac, BOARD1);
    chk("midrst_dmac", d_mac, BCAST);
    chk("midrst_idle", idle_th, 16'd1000);
    chk("midrst_enable", enable, 4'h0);
    chk("midrst_acc", frames_accepted, 8'd0);
    tvalid = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    chk("midrst_tready_back", tready, 1'b1);
    send_range(BOARD2, 16'h88B5, 8'h01, 8'h02, 32'h0000_0456, 17, 60, 60, -1);
    chk("midrst_cnt_th", counter_th, 12'd100);
    chk("midrst_tail_drop", frames_dropped, 8'd1);
    chk("midrst_tail_acc", frames_accepted, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
